ahb_master_iface: RTL and testbench

- Bus-side stage directly downstream of the master stimulus module.
- Converts the stimulus module's simple request bundle (addr, din, wr, enable, hbusreq_in, slv_sel_in) into single AHB-Lite/AHB transfers: arbitration request, address phase, data phase.
- Returns read data on dout and reports completion or error.
- One transfer per enable assertion. No bursts.

---
 rtl/ahb_master_iface.sv | 172 +++++++++++++++++
 tb/tb_ahb_master_iface.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_iface.sv
// Single-transfer AHB master: turns a simple stimulus request into an arbitration request,
// an address phase and a data phase, with RETRY/SPLIT replay and ERROR reporting.
module ahb_master_iface #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 4
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        slv_sel_in,
    input  logic [DATA_W-1:0] din,
    input  logic              wr,
    input  logic              enable,
    input  logic              hbusreq_in,
    output logic [DATA_W-1:0] dout,
    output logic              hbusreq,
    input  logic              hgrant,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    output logic [1:0]        hsel_id,
    input  logic              hready,
    input  logic [1:0]        hresp,
    input  logic [DATA_W-1:0] hrdata,
    output logic              busy,
    output logic              xfer_done,
    output logic              xfer_err
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_ERROR    = 2'b01;
    localparam logic [1:0] RESP_RETRY    = 2'b10;
    localparam logic [1:0] RESP_SPLIT    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA
    } state_t;

    state_t            state;
    logic              armed;
    logic              req_wait;
    logic [RW-1:0]     retry_cnt;
    logic [RW-1:0]     retry_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              wr_q;

    assign hsize      = 3'b010;
    assign hburst     = 3'b000;
    assign retry_next = retry_cnt + RW'(1);

    // The first REQ cycle only raises hbusreq; the grant is honoured from the second cycle
    // on, so a grant already present before our request was visible is never taken as ours.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= S_IDLE;
            armed     <= 1'b1;
            req_wait  <= 1'b0;
            retry_cnt <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            wr_q      <= 1'b0;
            dout      <= '0;
            hbusreq   <= 1'b0;
            haddr     <= '0;
            hwrite    <= 1'b0;
            htrans    <= HTRANS_IDLE;
            hwdata    <= '0;
            hsel_id   <= 2'b00;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
            if (!enable) armed <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (enable && hbusreq_in && armed) begin
                        addr_q    <= addr;
                        din_q     <= din;
                        wr_q      <= wr;
                        hsel_id   <= slv_sel_in;
                        armed     <= 1'b0;
                        retry_cnt <= '0;
                        req_wait  <= 1'b1;
                        hbusreq   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (!enable) begin
                        hbusreq <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else if (req_wait) begin
                        req_wait <= 1'b0;
                    end else if (hgrant && hready) begin
                        haddr   <= addr_q;
                        hwrite  <= wr_q;
                        htrans  <= HTRANS_NONSEQ;
                        hbusreq <= 1'b0;
                        state   <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        hwdata <= wr_q ? din_q : '0;
                        state  <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (hready) begin
                        if (hresp == RESP_OKAY) begin
                            if (!wr_q) dout <= hrdata;
                            xfer_done <= 1'b1;
                        end else begin
                            xfer_err <= 1'b1;
                        end
                        retry_cnt <= '0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        case (hresp)
                            RESP_ERROR: begin
                                xfer_err  <= 1'b1;
                                retry_cnt <= '0;
                                busy      <= 1'b0;
                                state     <= S_IDLE;
                            end
                            RESP_RETRY, RESP_SPLIT: begin
                                if (retry_next >= RW'(MAX_RETRY)) begin
                                    xfer_err  <= 1'b1;
                                    retry_cnt <= '0;
                                    busy      <= 1'b0;
                                    state     <= S_IDLE;
                                end else begin
                                    retry_cnt <= retry_next;
                                    req_wait  <= 1'b1;
                                    hbusreq   <= 1'b1;
                                    state     <= S_REQ;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_iface.sv
// Directed self-checking bench for ahb_master_iface: write, read with waits, delayed grant,
// abort, ERROR, RETRY/SPLIT replay and asynchronous reset in the middle of a transfer.
module tb_ahb_master_iface;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_RETRY = 4;

    logic              hclk;
    logic              hreset;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        slv_sel_in;
    logic [DATA_W-1:0] din;
    logic              wr;
    logic              enable;
    logic              hbusreq_in;
    logic [DATA_W-1:0] dout;
    logic              hbusreq;
    logic              hgrant;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [DATA_W-1:0] hwdata;
    logic [1:0]        hsel_id;
    logic              hready;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;
    logic              busy;
    logic              xfer_done;
    logic              xfer_err;

    int tests_run  = 0;
    int fail_count = 0;

    ahb_master_iface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY)) dut (
        .hclk(hclk), .hreset(hreset), .addr(addr), .slv_sel_in(slv_sel_in), .din(din),
        .wr(wr), .enable(enable), .hbusreq_in(hbusreq_in), .dout(dout), .hbusreq(hbusreq),
        .hgrant(hgrant), .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .hsel_id(hsel_id), .hready(hready), .hresp(hresp),
        .hrdata(hrdata), .busy(busy), .xfer_done(xfer_done), .xfer_err(xfer_err)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hreset = 1'b1; addr = '0; slv_sel_in = 2'b00; din = '0; wr = 1'b0; enable = 1'b0;
        hbusreq_in = 1'b0; hgrant = 1'b0; hready = 1'b1; hresp = 2'b00; hrdata = '0;
        tick(); tick();
        tests_run++; if (dout !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_dout: got %h expected 0", dout); end
        tests_run++; if (haddr !== 32'h0 || hwdata !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_bus: got haddr=%h hwdata=%h expected 0/0", haddr, hwdata); end
        tests_run++; if ({hbusreq, hwrite, busy, xfer_done, xfer_err} !== 5'b0) begin fail_count++; $display("[TB] FAIL reset_flags: got %b expected 00000", {hbusreq, hwrite, busy, xfer_done, xfer_err}); end
        tests_run++; if (htrans !== 2'b00 || hsel_id !== 2'b00) begin fail_count++; $display("[TB] FAIL reset_htrans: got htrans=%b hsel_id=%b expected 00/00", htrans, hsel_id); end
        tests_run++; if (hsize !== 3'b010 || hburst !== 3'b000) begin fail_count++; $display("[TB] FAIL reset_consts: got hsize=%b hburst=%b expected 010/000", hsize, hburst); end
        hreset = 1'b0;
        tick();
    endtask

    task automatic test_write_ok();
        int n_done, n_busy;
        addr = 32'h10; din = 32'h1; wr = 1'b1; slv_sel_in = 2'b10; enable = 1'b1;
        hbusreq_in = 1'b1; hgrant = 1'b1; hready = 1'b1; hresp = 2'b00;
        tick();
        tests_run++; if ({busy, hbusreq, htrans} !== 4'b1100) begin fail_count++; $display("[TB] FAIL write_req: got busy,hbusreq,htrans=%b expected 1100", {busy, hbusreq, htrans}); end
        tests_run++; if (hsel_id !== 2'b10) begin fail_count++; $display("[TB] FAIL write_hsel: got %b expected 10", hsel_id); end
        addr = 32'h55; din = 32'h99; wr = 1'b0; slv_sel_in = 2'b01;
        tick();
        tests_run++; if (htrans !== 2'b00 || hbusreq !== 1'b1) begin fail_count++; $display("[TB] FAIL write_req2: got htrans=%b hbusreq=%b expected 00/1", htrans, hbusreq); end
        tick();
        tests_run++; if (haddr !== 32'h10 || htrans !== 2'b10 || hwrite !== 1'b1 || hbusreq !== 1'b0) begin fail_count++; $display("[TB] FAIL write_addr: got haddr=%h htrans=%b hwrite=%b hbusreq=%b expected 10/10/1/0", haddr, htrans, hwrite, hbusreq); end
        tick();
        tests_run++; if (htrans !== 2'b00 || hwdata !== 32'h1 || xfer_done !== 1'b0 || hsel_id !== 2'b10) begin fail_count++; $display("[TB] FAIL write_data: got htrans=%b hwdata=%h done=%b hsel=%b expected 00/1/0/10", htrans, hwdata, xfer_done, hsel_id); end
        tick();
        tests_run++; if (xfer_done !== 1'b1 || busy !== 1'b0) begin fail_count++; $display("[TB] FAIL write_done: got done=%b busy=%b expected 1/0", xfer_done, busy); end
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (xfer_done) n_done++;
            if (busy) n_busy++;
        end
        tests_run++; if (n_done != 0 || n_busy != 0) begin fail_count++; $display("[TB] FAIL write_single: got done=%0d busy=%0d cycles expected 0/0", n_done, n_busy); end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_read_wait();
        int n_bad;
        addr = 32'h20; wr = 1'b0; hrdata = 32'hDEADBEEF; enable = 1'b1; hgrant = 1'b1; hready = 1'b1;
        tick(); tick(); tick();
        tests_run++; if (haddr !== 32'h20 || htrans !== 2'b10 || hwrite !== 1'b0) begin fail_count++; $display("[TB] FAIL read_addr: got haddr=%h htrans=%b hwrite=%b expected 20/10/0", haddr, htrans, hwrite); end
        tick();
        hready = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (htrans !== 2'b00 || haddr !== 32'h20 || busy !== 1'b1 || xfer_done !== 1'b0 || dout !== 32'h0) n_bad++;
        end
        tests_run++; if (n_bad != 0) begin fail_count++; $display("[TB] FAIL read_wait: got %0d unstable wait cycles expected 0", n_bad); end
        tests_run++; if (hwdata !== 32'h0) begin fail_count++; $display("[TB] FAIL read_hwdata: got %h expected 0", hwdata); end
        hready = 1'b1;
        tick();
        tests_run++; if (dout !== 32'hDEADBEEF || xfer_done !== 1'b1) begin fail_count++; $display("[TB] FAIL read_done: got dout=%h done=%b expected deadbeef/1", dout, xfer_done); end
        tick();
        tests_run++; if (xfer_done !== 1'b0) begin fail_count++; $display("[TB] FAIL read_pulse: got %b expected 0", xfer_done); end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_delayed_grant();
        int n_bad, n_pulse;
        hgrant = 1'b0; addr = 32'h30; din = 32'h5; wr = 1'b1; enable = 1'b1;
        tick();
        n_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (hbusreq !== 1'b1 || busy !== 1'b1 || htrans !== 2'b00) n_bad++;
        end
        tests_run++; if (n_bad != 0) begin fail_count++; $display("[TB] FAIL grant_wait: got %0d bad REQ cycles expected 0", n_bad); end
        hgrant = 1'b1;
        tick();
        tests_run++; if (htrans !== 2'b10 || haddr !== 32'h30) begin fail_count++; $display("[TB] FAIL grant_addr: got htrans=%b haddr=%h expected 10/30", htrans, haddr); end
        tick(); tick();
        tests_run++; if (xfer_done !== 1'b1) begin fail_count++; $display("[TB] FAIL grant_done: got %b expected 1", xfer_done); end
        enable = 1'b0;
        tick();
        hgrant = 1'b0; addr = 32'h31; enable = 1'b1;
        tick(); tick();
        enable = 1'b0;
        tick();
        tests_run++; if (busy !== 1'b0 || hbusreq !== 1'b0) begin fail_count++; $display("[TB] FAIL abort_idle: got busy=%b hbusreq=%b expected 0/0", busy, hbusreq); end
        hgrant = 1'b1;
        n_pulse = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (xfer_done || xfer_err || busy || htrans != 2'b00) n_pulse++;
        end
        tests_run++; if (n_pulse != 0) begin fail_count++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", n_pulse); end
    endtask

    task automatic test_error();
        addr = 32'h40; wr = 1'b0; hrdata = 32'h12345678; hgrant = 1'b1; hready = 1'b1; hresp = 2'b00; enable = 1'b1;
        tick(); tick(); tick(); tick();
        hready = 1'b0; hresp = 2'b01;
        tick();
        tests_run++; if (xfer_err !== 1'b1 || xfer_done !== 1'b0 || busy !== 1'b0) begin fail_count++; $display("[TB] FAIL error_pulse: got err=%b done=%b busy=%b expected 1/0/0", xfer_err, xfer_done, busy); end
        tests_run++; if (dout !== 32'hDEADBEEF) begin fail_count++; $display("[TB] FAIL error_dout: got %h expected deadbeef", dout); end
        hready = 1'b1;
        tick();
        tests_run++; if (xfer_err !== 1'b0 || busy !== 1'b0) begin fail_count++; $display("[TB] FAIL error_once: got err=%b busy=%b expected 0/0", xfer_err, busy); end
        hresp = 2'b00; enable = 1'b0;
        tick();
    endtask

    task automatic test_retry();
        int nret, attempts, n_addr_bad;
        logic [ADDR_W-1:0] exp_addr;
        logic [2:0] exp_flags;
        for (int scen = 0; scen < 3; scen++) begin
            nret     = (scen == 0) ? 4 : ((scen == 1) ? 1 : 3);
            attempts = (scen == 0) ? MAX_RETRY : nret + 1;
            exp_addr = 32'h50 + ADDR_W'(scen);
            addr = exp_addr; din = 32'h70; wr = 1'b1; enable = 1'b1; hgrant = 1'b1; hready = 1'b1; hresp = 2'b00;
            tick();
            addr = 32'h9;
            n_addr_bad = 0;
            for (int a = 0; a < attempts; a++) begin
                tick(); tick();
                if (haddr !== exp_addr || htrans !== 2'b10) n_addr_bad++;
                tick();
                if (a < nret) begin
                    hready = 1'b0;
                    hresp  = (a % 2 == 1) ? 2'b11 : 2'b10;
                    tick();
                    exp_flags = (a + 1 == MAX_RETRY) ? 3'b100 : 3'b011;
                    tests_run++; if ({xfer_err, busy, hbusreq} !== exp_flags) begin fail_count++; $display("[TB] FAIL retry_resp s%0d a%0d: got err,busy,hbusreq=%b expected %b", scen, a, {xfer_err, busy, hbusreq}, exp_flags); end
                    hready = 1'b1; hresp = 2'b00;
                end else begin
                    tick();
                    tests_run++; if (xfer_done !== 1'b1 || xfer_err !== 1'b0) begin fail_count++; $display("[TB] FAIL retry_done s%0d: got done=%b err=%b expected 1/0", scen, xfer_done, xfer_err); end
                end
            end
            tests_run++; if (n_addr_bad != 0) begin fail_count++; $display("[TB] FAIL retry_replay s%0d: got %0d bad address phases expected 0", scen, n_addr_bad); end
            enable = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        addr = 32'h60; din = 32'hAB; wr = 1'b1; slv_sel_in = 2'b11; enable = 1'b1; hgrant = 1'b1; hready = 1'b1; hresp = 2'b00;
        tick(); tick(); tick(); tick();
        hready = 1'b0;
        tick();
        #2;
        hreset = 1'b1;
        #1;
        tests_run++; if ({busy, hbusreq, htrans} !== 4'b0000 || hsel_id !== 2'b00) begin fail_count++; $display("[TB] FAIL rst_mid_ctrl: got busy,hbusreq,htrans=%b hsel=%b expected 0000/00", {busy, hbusreq, htrans}, hsel_id); end
        tests_run++; if (haddr !== 32'h0 || hwdata !== 32'h0 || dout !== 32'h0) begin fail_count++; $display("[TB] FAIL rst_mid_data: got haddr=%h hwdata=%h dout=%h expected 0/0/0", haddr, hwdata, dout); end
        hreset = 1'b0; hready = 1'b1; addr = 32'h64;
        tick();
        tests_run++; if (busy !== 1'b1) begin fail_count++; $display("[TB] FAIL rst_relaunch: got busy=%b expected 1", busy); end
        tick(); tick();
        tests_run++; if (haddr !== 32'h64 || htrans !== 2'b10) begin fail_count++; $display("[TB] FAIL rst_addr: got haddr=%h htrans=%b expected 64/10", haddr, htrans); end
        tick(); tick();
        tests_run++; if (xfer_done !== 1'b1) begin fail_count++; $display("[TB] FAIL rst_done: got %b expected 1", xfer_done); end
        enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_ok();
        test_read_wait();
        test_delayed_grant();
        test_error();
        test_retry();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
